param_memory: RTL and testbench
===============================

// Module: param_memory
// PURPOSE
//   Parametrised single-port synchronous memory: next generation of the team's tiny 64x198 store.
//   Adds configurable width/depth, per-lane write masking, pipelined read latency and a per-request done pulse.
//   Also adds an optional post-reset clear sweep and out-of-range error reporting.
//   Sits behind a controller that issues at most one request per cycle via sel/w.
// PARAMETERS
//   WIDTH          198  data word width in bits
//   LANE_W         66   write-mask lane width; WIDTH % LANE_W == 0, LANES = WIDTH/LANE_W
//   DEPTH          64   number of words; need not be a power of two
//   ADDR_W         6    address width; 2**ADDR_W >= DEPTH
//   RD_LAT         1    request-to-done latency in cycles, >= 1, applies to reads and writes
//   CLEAR_ON_RESET 1    1: zero every word after reset release; 0: contents untouched by reset
// PORTS
//   clk      in   1       clock, all state on rising edge
//   reset_n  in   1       asynchronous active-low reset
//   sel      in   1       request valid this cycle
//   w        in   1       1 = write, 0 = read (qualified by sel)
//   addr     in   ADDR_W  word address
//   wmask    in   LANES   per-lane write enable; bit i covers data[i*LANE_W +: LANE_W]
//   data     in   WIDTH   write data
//   out      out  WIDTH   read data, registered
//   done     out  1       one-cycle pulse, request completed
//   err      out  1       one-cycle pulse with done: completed request had addr >= DEPTH
//   busy     out  1       clear sweep in progress; requests not accepted
// BEHAVIOUR
//   Reset (reset_n=0, async): out=0, done=0, err=0, completion pipeline emptied, clear counter=0.
//     busy=1 if CLEAR_ON_RESET else 0. Array contents not reset asynchronously.
//   FSM states: CLEAR, IDLE.
//     Reset enters CLEAR if CLEAR_ON_RESET, else IDLE.
//   CLEAR: one word per cycle zeroed, addr 0..DEPTH-1.
//     -> IDLE on the edge that writes word DEPTH-1, so busy is high exactly DEPTH cycles after release.
//     sel ignored: no array access, no done, no err.
//   IDLE: request accepted on each edge with sel=1 (no backpressure); one per cycle, fully pipelined.
//   Write: lanes with wmask[i]=1 take data on the accept edge; other lanes keep old value.
//     wmask=0 is a legal no-op write and still completes.
//   Read: array sampled on the accept edge; out loads that word on the done edge.
//     out holds its value at all other times, including across writes.
//   Latency: done (and err) assert exactly RD_LAT cycles after the accept edge, for both reads and writes.
//     Back-to-back requests give back-to-back done pulses in issue order.
//   Read-after-write: a read accepted the cycle after a write to the same addr returns the new data.
//   Out of range (addr >= DEPTH): write discarded, read returns all-zero on out.
//     done still pulses, err=1 in the same cycle.
//   Reset mid-operation: in-flight requests dropped, no done/err for them.
//     Already-committed writes persist unless the clear sweep runs.
//   Reset asserted during CLEAR: sweep restarts from addr 0 after release.
// TESTING
//   1. Reset release with CLEAR_ON_RESET=1, DEPTH=64
//      -> busy high exactly 64 cycles; then read addr 63 -> out=0, done after RD_LAT.
//   2. Write addr 5 data=all-ones wmask=3'b111, then write addr 5 data=0 wmask=3'b010
//      -> read addr 5 gives out[65:0]=1s, out[131:66]=0, out[197:132]=1s.
//   3. RD_LAT=3: reads addr 1,2,3 on consecutive cycles (contents 0x11,0x22,0x33)
//      -> done high 3 consecutive cycles starting 3 after first accept; out=0x11,0x22,0x33 in order.
//   4. DEPTH=48, ADDR_W=6: write addr 50, then read addr 50
//      -> both complete with done=1, err=1; read out=0; addr 48-63 unaffected.
//   5. sel=1 during CLEAR (cycle 10 of sweep) -> no done/err ever issued for it; busy timing unchanged.
//   6. Issue read at RD_LAT=2, drop reset_n 1 cycle later
//      -> out=0, done never pulses; memory word written earlier still readable when CLEAR_ON_RESET=0.

Source files
------------

// File: rtl/param_memory.sv
// -----------------------------------------------------------------------------
// param_memory
//   Parametrised single-port synchronous memory with per-lane write masking,
//   a fixed request-to-done latency for reads and writes, an optional
//   post-reset clear sweep and out-of-range error reporting.
//
// Ports
//   clk      in   1       clock, all state on rising edge
//   reset_n  in   1       asynchronous active-low reset
//   sel      in   1       request valid this cycle
//   w        in   1       1 = write, 0 = read (qualified by sel)
//   addr     in   ADDR_W  word address
//   wmask    in   LANES   per-lane write enable, bit i covers data[i*LANE_W +: LANE_W]
//   data     in   WIDTH   write data
//   out      out  WIDTH   read data, registered, holds between read completions
//   done     out  1       one-cycle pulse, request completed
//   err      out  1       one-cycle pulse with done, completed request had addr >= DEPTH
//   busy     out  1       clear sweep in progress, requests ignored
// -----------------------------------------------------------------------------
module param_memory #(
  parameter int WIDTH          = 198,
  parameter int LANE_W         = 66,
  parameter int DEPTH          = 64,
  parameter int ADDR_W         = 6,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sel,
  input  logic                      w,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [WIDTH/LANE_W-1:0]   wmask,
  input  logic [WIDTH-1:0]          data,
  output logic [WIDTH-1:0]          out,
  output logic                      done,
  output logic                      err,
  output logic                      busy
);

  localparam int LANES = WIDTH / LANE_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                clr_we;

  logic [WIDTH-1:0]    mem_q [DEPTH];

  logic                accept;
  logic                in_range;
  logic [WIDTH-1:0]    rd_word;

  // Completion pipeline: stage k holds a request accepted k edges ago.
  logic [RD_LAT-1:0]   vld_q;
  logic [RD_LAT-1:0]   rd_q;
  logic [RD_LAT-1:0]   err_q;
  logic [WIDTH-1:0]    dat_q [RD_LAT];

  logic [WIDTH-1:0]    out_q;
  logic                done_q;
  logic                err_out_q;

  // ---------------------------------------------------------------------------
  // Control FSM: clear sweep then idle
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        // Gated with reset_n so a held reset does not keep hammering word 0.
        clr_we = reset_n;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign busy = (state_q == ST_CLEAR);

  // ---------------------------------------------------------------------------
  // Request decode and array access
  // ---------------------------------------------------------------------------
  assign accept   = sel && (state_q == ST_IDLE) && reset_n;
  assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
  assign rd_word  = in_range ? mem_q[addr] : '0;

  // Array has no reset: contents survive reset unless the sweep runs.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (accept && w && in_range) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) begin
          mem_q[addr][i*LANE_W +: LANE_W] <= data[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Completion pipeline, control part (cleared by reset so in-flight
  // requests are dropped)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      rd_q  <= '0;
      err_q <= '0;
    end else begin
      vld_q[0] <= accept;
      rd_q[0]  <= ~w;
      err_q[0] <= ~in_range;
      for (int k = 1; k < RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        rd_q[k]  <= rd_q[k-1];
        err_q[k] <= err_q[k-1];
      end
    end
  end

  // Data part: the word is sampled on the accept edge so that a read
  // accepted right after a write sees the written value.
  always_ff @(posedge clk) begin
    dat_q[0] <= rd_word;
    for (int k = 1; k < RD_LAT; k++) begin
      dat_q[k] <= dat_q[k-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: done/err/out update RD_LAT edges after accept
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q    <= 1'b0;
      err_out_q <= 1'b0;
      out_q     <= '0;
    end else begin
      done_q    <= vld_q[RD_LAT-1];
      err_out_q <= vld_q[RD_LAT-1] & err_q[RD_LAT-1];
      if (vld_q[RD_LAT-1] && rd_q[RD_LAT-1]) begin
        out_q <= dat_q[RD_LAT-1];
      end
    end
  end

  assign out  = out_q;
  assign done = done_q;
  assign err  = err_out_q;

endmodule

// File: tb/tb_param_memory.sv
module tb_param_memory;

  localparam int W = 198;

  // Instance 0: DEPTH 64, RD_LAT 1, clear on reset
  // Instance 1: DEPTH 48, RD_LAT 3, clear on reset
  // Instance 2: DEPTH 64, RD_LAT 2, no clear
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic           rst_n_s [NI];
  logic           sel_s   [NI];
  logic           w_s     [NI];
  logic [5:0]     addr_s  [NI];
  logic [2:0]     wmask_s [NI];
  logic [W-1:0]   data_s  [NI];
  logic [W-1:0]   out_s   [NI];
  logic           done_s  [NI];
  logic           err_s   [NI];
  logic           busy_s  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    param_memory #(
      .WIDTH(198), .LANE_W(66),
      .DEPTH(g == 1 ? 48 : 64), .ADDR_W(6),
      .RD_LAT(g == 0 ? 1 : (g == 1 ? 3 : 2)),
      .CLEAR_ON_RESET(g == 2 ? 0 : 1)
    ) u_dut (
      .clk(clk), .reset_n(rst_n_s[g]), .sel(sel_s[g]), .w(w_s[g]),
      .addr(addr_s[g]), .wmask(wmask_s[g]), .data(data_s[g]),
      .out(out_s[g]), .done(done_s[g]), .err(err_s[g]), .busy(busy_s[g])
    );
  end

  function automatic int lat(int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 2);
  endfunction

  typedef struct {
    int           g;
    int           cyc;
    bit           chk_out;
    logic [W-1:0] out;
    bit           err;
  } exp_t;

  exp_t sbq[$];
  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < NI; g++) begin
      if (done_s[g] === 1'b1) begin
        if (sbq.size() == 0) begin
          total++;
          $display("FAIL unexpected_done inst%0d cycle %0d: done=1 expected no completion", g, cyc);
        end else begin
          e = sbq.pop_front();
          chk("done_inst", W'(g), W'(e.g));
          chk("done_cycle", W'(cyc), W'(e.cyc));
          chk("err", W'(err_s[g]), W'(e.err));
          if (e.chk_out) chk("out", out_s[g], e.out);
        end
      end else if (err_s[g] !== 1'b0) begin
        total++;
        $display("FAIL err_without_done inst%0d cycle %0d: err=%b expected 0", g, cyc, err_s[g]);
      end
    end
  end

  task automatic clear_sel();
    for (int i = 0; i < NI; i++) sel_s[i] = 1'b0;
  endtask

  task automatic issue(input int g, input bit wr, input int a, input logic [2:0] m,
                       input logic [W-1:0] d, input bit exp_done,
                       input logic [W-1:0] eout, input bit eerr);
    exp_t e;
    @(posedge clk); #1;
    clear_sel();
    sel_s[g]   = 1'b1;
    w_s[g]     = wr;
    addr_s[g]  = 6'(a);
    wmask_s[g] = m;
    data_s[g]  = d;
    if (exp_done) begin
      e.g       = g;
      e.cyc     = cyc + 1 + lat(g);
      e.chk_out = !wr;
      e.out     = eout;
      e.err     = eerr;
      sbq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      clear_sel();
    end
  endtask

  logic [W-1:0] ones, zero, mix, pat, lane0;
  int cnt [NI];

  initial begin
    ones  = '1;
    zero  = '0;
    mix   = {{66{1'b1}}, {66{1'b0}}, {66{1'b1}}};
    pat   = {66'h3_0123_4567_89AB_CDEF, 66'h1_FEDC_BA98_7654_3210, 66'h2_5A5A_A5A5_0F0F_F0F0};
    lane0 = {132'b0, {66{1'b1}}};
    for (int i = 0; i < NI; i++) begin
      rst_n_s[i] = 1'b0; sel_s[i] = 1'b0; w_s[i] = 1'b0;
      addr_s[i] = '0; wmask_s[i] = '0; data_s[i] = '0; cnt[i] = 0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      chk("rst_out", out_s[g], zero);
      chk("rst_done", W'(done_s[g]), W'(0));
      chk("rst_err", W'(err_s[g]), W'(0));
      chk("rst_busy", W'(busy_s[g]), W'(g == 2 ? 0 : 1));
    end

    // Release and measure the clear sweep; poke instance 1 mid-sweep
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) rst_n_s[i] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) if (busy_s[g] === 1'b1) cnt[g]++;
      if (k == 9) begin
        sel_s[1] = 1'b1; w_s[1] = 1'b0; addr_s[1] = 6'd0;
      end
      if (k == 10) sel_s[1] = 1'b0;
    end
    chk("busy_cycles_d64", W'(cnt[0]), W'(64));
    chk("busy_cycles_d48", W'(cnt[1]), W'(48));
    chk("busy_cycles_noclear", W'(cnt[2]), W'(0));

    // Cleared words read back zero
    issue(0, 0, 63, 3'b000, zero, 1, zero, 0);
    issue(0, 0, 0, 3'b000, zero, 1, zero, 0);
    idle(3);

    // Lane masking, read-after-write, no-op write
    issue(0, 1, 5, 3'b111, ones, 1, zero, 0);
    issue(0, 1, 5, 3'b010, zero, 1, zero, 0);
    issue(0, 0, 5, 3'b000, zero, 1, mix, 0);
    issue(0, 1, 5, 3'b000, zero, 1, zero, 0);
    issue(0, 0, 5, 3'b000, zero, 1, mix, 0);
    issue(0, 1, 6, 3'b001, ones, 1, zero, 0);
    issue(0, 0, 6, 3'b000, zero, 1, lane0, 0);
    idle(3);

    // RD_LAT=3 back-to-back
    issue(1, 1, 1, 3'b111, W'(8'h11), 1, zero, 0);
    issue(1, 1, 2, 3'b111, W'(8'h22), 1, zero, 0);
    issue(1, 1, 3, 3'b111, W'(8'h33), 1, zero, 0);
    issue(1, 0, 1, 3'b000, zero, 1, W'(8'h11), 0);
    issue(1, 0, 2, 3'b000, zero, 1, W'(8'h22), 0);
    issue(1, 0, 3, 3'b000, zero, 1, W'(8'h33), 0);
    idle(5);

    // Out of range on DEPTH=48
    issue(1, 1, 50, 3'b111, ones, 1, zero, 1);
    issue(1, 0, 50, 3'b000, zero, 1, zero, 1);
    issue(1, 0, 47, 3'b000, zero, 1, zero, 0);
    issue(1, 0, 63, 3'b000, zero, 1, zero, 1);
    issue(1, 0, 2, 3'b000, zero, 1, W'(8'h22), 0);
    idle(5);

    // Reset mid-flight on the non-clearing instance
    issue(2, 1, 7, 3'b111, pat, 1, zero, 0);
    issue(2, 0, 7, 3'b000, zero, 1, pat, 0);
    idle(4);
    issue(2, 0, 7, 3'b000, zero, 0, zero, 0);
    @(posedge clk); #1;
    clear_sel();
    @(posedge clk); #1;
    rst_n_s[2] = 1'b0;
    #1;
    chk("midrst_out", out_s[2], zero);
    chk("midrst_done", W'(done_s[2]), W'(0));
    chk("midrst_busy", W'(busy_s[2]), W'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n_s[2] = 1'b1;
    idle(5);
    issue(2, 0, 7, 3'b000, zero, 1, pat, 0);
    idle(5);

    total++;
    if (sbq.size() == 0) passed++;
    else $display("FAIL missing_done: %0d completions outstanding, expected 0", sbq.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
